// File: rtl/id_buf_pkg.sv
// Shared types, widths and pointer helper for the ID1->ID2 dual-issue buffer.
package id_buf_pkg;

  localparam int PW        = 32;
  localparam int IW        = 32;
  localparam int BW        = 34;
  localparam int EW        = 8;
  localparam int ENT_W     = PW + IW + BW + EW;
  localparam int MAX_DEPTH = 64;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [IW-1:0] ir;
    logic [BW-1:0] brtype_pcpre;
    logic [EW-1:0] ecode;
  } id_entry_t;

  // msb marks the top live bit; that bit wraps to bit 0 and everything else shifts up.
  function automatic logic [MAX_DEPTH-1:0] onehot_rotl(
    input logic [MAX_DEPTH-1:0] v,
    input logic [MAX_DEPTH-1:0] msb
  );
    return ((v & ~msb) << 1) | {{(MAX_DEPTH-1){1'b0}}, |(v & msb)};
  endfunction

endpackage

// File: rtl/onehot_read_mux.sv
// AND-OR selector: returns the word whose one-hot select bit is set.
module onehot_read_mux #(
  parameter int DEPTH = 16,
  parameter int W     = 106
) (
  input  logic [DEPTH-1:0]        i_sel,
  input  logic [DEPTH-1:0][W-1:0] i_data,
  output logic [W-1:0]            o_data
);

  always_comb begin
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_data = o_data | (i_data[i] & {W{i_sel[i]}});
    end
  end

endmodule

// File: rtl/id_dual_issue_buffer.sv
// Two-bank interleaved instruction queue between ID1 and ID2; presents the
// two oldest entries in program order with one-hot pointers and AND-OR reads.
module id_dual_issue_buffer #(
  parameter int DEPTH = 16,
  parameter int PW    = id_buf_pkg::PW,
  parameter int IW    = id_buf_pkg::IW,
  parameter int BW    = id_buf_pkg::BW,
  parameter int EW    = id_buf_pkg::EW,
  localparam int ENT_W = PW + IW + BW + EW,
  localparam int CW    = $clog2(2*DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       in_valid,
  input  logic [ENT_W-1:0] in_entry0,
  input  logic [ENT_W-1:0] in_entry1,
  output logic             in_ready,
  output logic [1:0]       out_valid,
  output logic [ENT_W-1:0] out_entry0,
  output logic [ENT_W-1:0] out_entry1,
  input  logic [1:0]       out_ready,
  output logic [CW-1:0]    count
);
  import id_buf_pkg::*;

  localparam logic [MAX_DEPTH-1:0] MSB      = MAX_DEPTH'(1) << (DEPTH - 1);
  localparam logic [CW-1:0]        PUSH_LIM = CW'(2*DEPTH - 2);
  localparam logic [DEPTH-1:0]     PTR_INIT = DEPTH'(1);

  logic [DEPTH-1:0][ENT_W-1:0] r_bank_a, r_bank_b;
  logic [DEPTH-1:0]            r_tail_a, r_tail_b, r_head_a, r_head_b;
  logic                        r_wbank, r_rbank;
  logic [CW-1:0]               r_count;

  logic             w_push0, w_push1, w_pop0, w_pop1;
  logic             w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic [1:0]       w_push_n, w_pop_n;
  logic [ENT_W-1:0] w_din_a, w_din_b, w_head_a, w_head_b;

  assign count     = r_count;
  assign in_ready  = (r_count <= PUSH_LIM);
  assign out_valid = {(r_count > CW'(1)), (r_count != '0)};

  assign w_push0  = in_valid[0] & in_ready;
  assign w_push1  = w_push0 & in_valid[1];
  assign w_pop0   = out_ready[0] & out_valid[0];
  assign w_pop1   = out_ready[0] & out_ready[1] & out_valid[1];
  assign w_push_n = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_pop_n  = {1'b0, w_pop0} + {1'b0, w_pop1};

  // Lane k of a push lands in bank w_bank^k; lane k of a pop drains bank r_bank^k.
  assign w_wr_a  = (w_push0 & ~r_wbank) | (w_push1 & r_wbank);
  assign w_wr_b  = (w_push0 & r_wbank) | (w_push1 & ~r_wbank);
  assign w_din_a = r_wbank ? in_entry1 : in_entry0;
  assign w_din_b = r_wbank ? in_entry0 : in_entry1;
  assign w_rd_a  = (w_pop0 & ~r_rbank) | (w_pop1 & r_rbank);
  assign w_rd_b  = (w_pop0 & r_rbank) | (w_pop1 & ~r_rbank);

  onehot_read_mux #(.DEPTH(DEPTH), .W(ENT_W)) u_mux_a (
    .i_sel  (r_head_a),
    .i_data (r_bank_a),
    .o_data (w_head_a)
  );

  onehot_read_mux #(.DEPTH(DEPTH), .W(ENT_W)) u_mux_b (
    .i_sel  (r_head_b),
    .i_data (r_bank_b),
    .o_data (w_head_b)
  );

  assign out_entry0 = r_rbank ? w_head_b : w_head_a;
  assign out_entry1 = r_rbank ? w_head_a : w_head_b;

  // Storage: cleared only by rst; flush leaves stale data behind the reset pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_a <= '0;
      r_bank_b <= '0;
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_a && r_tail_a[i]) r_bank_a[i] <= w_din_a;
        if (w_wr_b && r_tail_b[i]) r_bank_b[i] <= w_din_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_tail_a <= PTR_INIT;
      r_tail_b <= PTR_INIT;
      r_head_a <= PTR_INIT;
      r_head_b <= PTR_INIT;
      r_wbank  <= 1'b0;
      r_rbank  <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_wr_a) r_tail_a <= DEPTH'(onehot_rotl(MAX_DEPTH'(r_tail_a), MSB));
      if (w_wr_b) r_tail_b <= DEPTH'(onehot_rotl(MAX_DEPTH'(r_tail_b), MSB));
      if (w_rd_a) r_head_a <= DEPTH'(onehot_rotl(MAX_DEPTH'(r_head_a), MSB));
      if (w_rd_b) r_head_b <= DEPTH'(onehot_rotl(MAX_DEPTH'(r_head_b), MSB));
      if (w_push0 && !w_push1) r_wbank <= ~r_wbank;
      if (w_pop0 && !w_pop1)   r_rbank <= ~r_rbank;
      r_count <= r_count + CW'(w_push_n) - CW'(w_pop_n);
    end
  end

endmodule
